// File: rtl/cache_mem_arbiter.sv
// Arbiter that lets the I-cache and D-cache share one burst memory port.
// A whole 256-bit line moves as four 64-bit beats. Reads fill a line buffer
// that both caches see. Writebacks come only from the D-cache and stream
// d_wdata out one beat at a time.
module cache_mem_arbiter #(
  parameter int unsigned RR_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_addr,
  input  logic         i_read,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic [31:0]  d_addr,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  typedef enum logic [2:0] {StIdle, StRdIssue, StRdWait, StWrBurst, StResp} state_e;

  state_e         state_q;
  logic           owner_d_q;  // 1: D-cache owns the current transaction
  logic           last_d_q;   // 1: D-cache was served last
  logic [1:0]     beat_q;
  logic [255:0]   line_q;

  logic           i_req;
  logic           d_req;
  logic           grant_d;
  logic [31:0]    grant_addr;

  // Choose the winner among pending requests and select the beat to write.
  always_comb begin
    i_req = i_read;
    d_req = d_read | d_write;
    if (i_req && d_req) begin
      grant_d = (RR_EN == 0) ? 1'b1 : !last_d_q;
    end else begin
      grant_d = d_req;
    end
    grant_addr = grant_d ? d_addr : i_addr;
    bmem_wdata = bmem_write ? d_wdata[{beat_q, 6'd0} +: 64] : '0;
  end

  // Both caches read the same line buffer. It holds its value until the next fill.
  assign i_rdata = line_q;
  assign d_rdata = line_q;

  // Transaction FSM with registered command and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_d_q  <= 1'b0;
      last_d_q   <= 1'b0;
      beat_q     <= 2'd0;
      line_q     <= '0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_req || d_req) begin
            owner_d_q <= grant_d;
            bmem_addr <= grant_addr & 32'hffff_ffe0;
            beat_q    <= 2'd0;
            // If read and write are both raised, the write wins.
            if (grant_d && d_write) begin
              bmem_write <= 1'b1;
              state_q    <= StWrBurst;
            end else begin
              bmem_read <= 1'b1;
              state_q   <= StRdIssue;
            end
          end
        end
        StRdIssue: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            state_q   <= StRdWait;
          end
        end
        StRdWait: begin
          if (bmem_rvalid) begin
            line_q[{beat_q, 6'd0} +: 64] <= bmem_rdata;
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              i_resp  <= !owner_d_q;
              d_resp  <= owner_d_q;
              state_q <= StResp;
            end
          end
        end
        StWrBurst: begin
          if (bmem_ready) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              bmem_write <= 1'b0;
              d_resp     <= 1'b1;
              state_q    <= StResp;
            end
          end
        end
        StResp: begin
          last_d_q <= owner_d_q;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter. A behavioural memory and the
// requester behaviour are modelled one cycle at a time. A round-robin
// instance and a fixed-priority instance share the inputs, and a mux picks
// which instance the model watches.
module tb_cache_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [31:0]  i_addr = '0;
  logic [31:0]  d_addr = '0;
  logic         i_read = 1'b0;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [255:0] d_wdata = '0;
  logic         bmem_ready = 1'b0;
  logic         bmem_rvalid = 1'b0;
  logic [63:0]  bmem_rdata = '0;
  logic         sel_fp = 1'b0;

  logic [255:0] rr_i_rdata, rr_d_rdata, fp_i_rdata, fp_d_rdata;
  logic         rr_i_resp, rr_d_resp, fp_i_resp, fp_d_resp;
  logic [31:0]  rr_bmem_addr, fp_bmem_addr;
  logic         rr_bmem_read, rr_bmem_write, fp_bmem_read, fp_bmem_write;
  logic [63:0]  rr_bmem_wdata, fp_bmem_wdata;

  logic [255:0] i_rdata, d_rdata;
  logic         i_resp, d_resp, bmem_read, bmem_write;
  logic [31:0]  bmem_addr;
  logic [63:0]  bmem_wdata;

  assign i_rdata    = sel_fp ? fp_i_rdata    : rr_i_rdata;
  assign d_rdata    = sel_fp ? fp_d_rdata    : rr_d_rdata;
  assign i_resp     = sel_fp ? fp_i_resp     : rr_i_resp;
  assign d_resp     = sel_fp ? fp_d_resp     : rr_d_resp;
  assign bmem_addr  = sel_fp ? fp_bmem_addr  : rr_bmem_addr;
  assign bmem_read  = sel_fp ? fp_bmem_read  : rr_bmem_read;
  assign bmem_write = sel_fp ? fp_bmem_write : rr_bmem_write;
  assign bmem_wdata = sel_fp ? fp_bmem_wdata : rr_bmem_wdata;

  cache_mem_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(rr_i_rdata), .i_resp(rr_i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(rr_d_rdata), .d_resp(rr_d_resp),
    .bmem_addr(rr_bmem_addr), .bmem_read(rr_bmem_read), .bmem_write(rr_bmem_write),
    .bmem_wdata(rr_bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  cache_mem_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(fp_i_rdata), .i_resp(fp_i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(fp_d_rdata), .d_resp(fp_d_resp),
    .bmem_addr(fp_bmem_addr), .bmem_read(fp_bmem_read), .bmem_write(fp_bmem_write),
    .bmem_wdata(fp_bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc_cnt = 0;

  // Memory and requester model state.
  logic [255:0] next_line = '0;
  logic [255:0] mem_line = '0;
  logic [255:0] last_fill = '0;
  int           rd_left = 0;
  int           rd_idx = 0;
  int           gap = 0;
  int           gap_max = 0;
  bit           rd_abort = 1'b0;
  bit           stray = 1'b0;
  bit           rdy_rand = 1'b0;
  int           stall_beat = -1;
  int           stall_left = 0;
  logic [31:0]  acc_addr = '0;
  logic [31:0]  wr_addr = '0;
  logic [63:0]  wr_q[$];
  int           served[$];
  bit           prev_i_resp = 1'b0;
  bit           prev_d_resp = 1'b0;
  bit           prev_rd_acc = 1'b0;
  int           d_repeat = 0;
  bit           d_again = 1'b0;
  int           i_resp_cyc = 0;
  int           d_resp_cyc = 0;

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    #1;
    check(tag, 256'(i_resp | d_resp | bmem_read | bmem_write) | 256'(bmem_addr) |
               256'(bmem_wdata) | i_rdata | d_rdata, '0);
  endtask

  // One clock: look at the outputs at negedge, update the model, drive inputs, then wait for posedge.
  task automatic cyc();
    int idx;
    @(negedge clk);
    cyc_cnt++;
    if (d_again) begin
      d_again = 1'b0;
      d_read  = 1'b1;
    end
    if (prev_i_resp) check("i_resp_pulse", 256'(i_resp), 256'(0));
    if (prev_d_resp) check("d_resp_pulse", 256'(d_resp), 256'(0));
    if (prev_rd_acc) check("read_one_accept", 256'(bmem_read), 256'(0));
    prev_rd_acc = 1'b0;
    if (bmem_read || bmem_write) check("addr_aligned", 256'(bmem_addr[4:0]), 256'(0));
    if (bmem_write) begin
      idx = wr_q.size();
      if (idx < 4) check("wr_beat", 256'(bmem_wdata), 256'(d_wdata[idx*64 +: 64]));
    end
    if (i_resp) begin
      check("i_line", i_rdata, last_fill);
      check("i_addr", 256'(acc_addr), 256'(align(i_addr)));
      served.push_back(0);
      i_resp_cyc = cyc_cnt;
      i_read = 1'b0;
    end
    if (d_resp) begin
      if (d_write) begin
        check("wr_count", 256'(wr_q.size()), 256'(4));
        if (wr_q.size() == 4) check("wr_line", {wr_q[3], wr_q[2], wr_q[1], wr_q[0]}, d_wdata);
        check("wr_addr", 256'(wr_addr), 256'(align(d_addr)));
        check("line_kept", d_rdata, last_fill);
      end else begin
        check("d_line", d_rdata, last_fill);
        check("d_addr", 256'(acc_addr), 256'(align(d_addr)));
      end
      wr_q.delete();
      served.push_back(1);
      d_resp_cyc = cyc_cnt;
      d_read  = 1'b0;
      d_write = 1'b0;
      if (d_repeat > 0) begin
        d_repeat--;
        d_again = 1'b1;
      end
    end
    prev_i_resp = i_resp;
    prev_d_resp = d_resp;

    // Send read beats after a random gap. Beats that arrive after an abort must not change the fill model.
    bmem_rvalid = 1'b0;
    bmem_rdata  = {$urandom(), $urandom()};
    if (rd_left > 0) begin
      if (gap == 0) begin
        bmem_rvalid = 1'b1;
        bmem_rdata  = mem_line[rd_idx*64 +: 64];
        rd_idx++;
        rd_left--;
        gap = int'($urandom_range(gap_max));
        if (rd_left == 0) begin
          if (rd_abort) rd_abort = 1'b0;
          else last_fill = mem_line;
        end
      end else begin
        gap--;
      end
    end else if (stray) begin
      bmem_rvalid = 1'b1;
      stray = 1'b0;
    end

    bmem_ready = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
    if (bmem_write && stall_left > 0 && wr_q.size() == stall_beat) begin
      bmem_ready = 1'b0;
      stall_left--;
    end
    if (bmem_read && bmem_ready) begin
      acc_addr    = bmem_addr;
      mem_line    = next_line;
      next_line   = rand256();
      rd_left     = 4;
      rd_idx      = 0;
      gap         = int'($urandom_range(gap_max));
      prev_rd_acc = 1'b1;
    end
    if (bmem_write && bmem_ready) begin
      if (wr_q.size() > 0) check("wr_addr_hold", 256'(bmem_addr), 256'(wr_addr));
      wr_addr = bmem_addr;
      wr_q.push_back(bmem_wdata);
    end
    @(posedge clk);
  endtask

  task automatic do_reset(input bit fp);
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    d_repeat = 0; d_again = 1'b0; stall_left = 0;
    if (rd_left > 0) rd_abort = 1'b1;
    cyc();
    sel_fp = fp;
    wr_q.delete();
    prev_i_resp = 1'b0; prev_d_resp = 1'b0; prev_rd_acc = 1'b0;
    last_fill = '0;
    check_zero("outs_zero_in_rst");
    cyc();
    rst = 1'b0;
    cyc();
    check_zero("outs_zero_after_rst");
  endtask

  task automatic wait_served(input int n, input int budget, input string tag);
    int k = 0;
    while (served.size() < n && k < budget) begin
      cyc();
      k++;
    end
    check(tag, 256'(served.size() >= n), 256'(1));
  endtask

  initial begin
    int base;
    int n;
    int winner;
    int op;

    next_line = rand256();
    do_reset(1'b0);

    // A single I-cache read with fixed beats and memory ready on every cycle.
    gap_max = 0;
    next_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    i_addr = 32'h0000_1234;
    i_read = 1'b1;
    base = cyc_cnt;
    n = served.size();
    wait_served(n + 1, 50, "i_read_done");
    check("i_bmem_addr", 256'(acc_addr), 256'(32'h0000_1220));
    check("i_beat0", 256'(i_rdata[63:0]), 256'(64'h1111_1111_1111_1111));
    check("i_beat3", 256'(i_rdata[255:192]), 256'(64'h4444_4444_4444_4444));
    check("rd_latency", 256'(i_resp_cyc - base), 256'(7));

    // An unstalled writeback completes six cycles after the request.
    d_addr  = 32'h8000_0040;
    d_wdata = 256'h0123456789abcdef_1032547698badcfe_89abcdef01234567_fedcba9876543210;
    d_write = 1'b1;
    base = cyc_cnt;
    n = served.size();
    wait_served(n + 1, 50, "wr_done");
    check("wr_latency", 256'(d_resp_cyc - base), 256'(6));

    // Read and write raised together count as a write. Beat 1 is stalled for 2 cycles.
    stall_beat = 1;
    stall_left = 2;
    d_read  = 1'b1;
    d_write = 1'b1;
    base = cyc_cnt;
    n = served.size();
    wait_served(n + 1, 50, "wr_stall_done");
    check("wr_stall_latency", 256'(d_resp_cyc - base), 256'(8));
    stall_beat = -1;

    // Round-robin: D wins the first conflict after reset.
    do_reset(1'b0);
    i_addr = $urandom(); d_addr = $urandom();
    i_read = 1'b1; d_read = 1'b1;
    n = served.size();
    wait_served(n + 2, 80, "rr_pair1_done");
    if (served.size() >= n + 2) begin
      check("rr_first_d", 256'(served[n]), 256'(1));
      check("rr_then_i", 256'(served[n+1]), 256'(0));
    end
    d_read = 1'b1;
    n = served.size();
    wait_served(n + 1, 50, "d_alone_done");
    i_read = 1'b1; d_read = 1'b1;
    n = served.size();
    wait_served(n + 2, 80, "rr_pair2_done");
    if (served.size() >= n + 2) begin
      check("rr_first_i", 256'(served[n]), 256'(0));
      check("rr_then_d", 256'(served[n+1]), 256'(1));
    end

    // Random conflicts with beat gaps, random ready and stray rvalid while idle.
    gap_max = 3;
    rdy_rand = 1'b1;
    for (int r = 0; r < 20; r++) begin
      winner = (served[served.size()-1] == 0) ? 1 : 0;
      stray = ($urandom_range(1) == 1);
      i_addr = $urandom();
      d_addr = $urandom();
      d_wdata = rand256();
      op = int'($urandom_range(2));
      i_read = 1'b1;
      d_read = (op != 1);
      d_write = (op != 0);
      n = served.size();
      wait_served(n + 2, 300, "rand_pair_done");
      if (served.size() >= n + 2) check("rand_rr_order", 256'(served[n]), 256'(winner));
    end

    // Reset during RD_WAIT after two beats: no response, and later beats are ignored.
    gap_max = 0;
    rdy_rand = 1'b0;
    i_addr = $urandom();
    i_read = 1'b1;
    base = 0;
    while (!(rd_left > 0 && rd_idx == 2) && base < 30) begin
      cyc();
      base++;
    end
    check("reached_two_beats", 256'(rd_idx == 2), 256'(1));
    n = served.size();
    do_reset(1'b0);
    repeat (4) cyc();
    check("abort_no_resp", 256'(served.size()), 256'(n));
    check("stale_beats_ignored", i_rdata, '0);
    i_read = 1'b1;
    n = served.size();
    wait_served(n + 1, 50, "read_after_abort");
    check("fresh_line_nonzero", 256'(i_rdata != '0), 256'(1));

    // Fixed priority: D re-requests at once every time, so I must wait.
    do_reset(1'b1);
    gap_max = 1;
    d_repeat = 3;
    i_addr = $urandom(); d_addr = $urandom();
    i_read = 1'b1; d_read = 1'b1;
    n = served.size();
    wait_served(n + 5, 300, "fp_done");
    if (served.size() >= n + 5) begin
      for (int k = 0; k < 4; k++) check("fp_d_wins", 256'(served[n+k]), 256'(1));
      check("fp_i_last", 256'(served[n+4]), 256'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
Parameters:
REQ-001 RR_EN, default 1, SHALL select arbitration: 1 = round-robin; 0 = fixed priority with D-cache winning.
Ports:
REQ-002 clk  in  1  SHALL be the clock; all state updates on posedge.
REQ-003 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 i_addr  in  32  SHALL be the I-cache line request address.
REQ-005 i_read  in  1  SHALL be the I-cache line read request, held until i_resp.
REQ-006 i_rdata  out  256  SHALL be the line returned to the I-cache.
REQ-007 i_resp  out  1  SHALL be the one-cycle I-cache completion pulse.
REQ-008 d_addr  in  32  SHALL be the D-cache line request address.
REQ-009 d_read  in  1  SHALL be the D-cache line read request, held until d_resp.
REQ-010 d_write  in  1  SHALL be the D-cache line writeback request, held until d_resp.
REQ-011 d_wdata  in  256  SHALL be the writeback line, stable while d_write=1.
REQ-012 d_rdata  out  256  SHALL be the line returned to the D-cache.
REQ-013 d_resp  out  1  SHALL be the one-cycle D-cache completion pulse.
REQ-014 bmem_addr  out  32  SHALL be the memory address, always 32-byte aligned ({addr[31:5],5'b0}).
REQ-015 bmem_read  out  1  SHALL be the memory read command.
REQ-016 bmem_write  out  1  SHALL be the memory write-beat strobe.
REQ-017 bmem_wdata  out  64  SHALL be the write beat.
REQ-018 bmem_ready  in  1  SHALL indicate that memory accepts a command or beat this cycle.
REQ-019 bmem_rdata  in  64  SHALL be the read beat.
REQ-020 bmem_rvalid  in  1  SHALL qualify bmem_rdata.

Function
REQ-021 The FSM SHALL have exactly these states: IDLE, RD_ISSUE, RD_WAIT, WR_BURST, RESP.
REQ-022 In IDLE with any request pending, the arbiter SHALL register the grant (owner, op, aligned address) and go to RD_ISSUE (read) or WR_BURST (write).
REQ-023 Arbitration SHALL follow RR_EN: with RR_EN=1 and both caches pending, the requester not served last wins; with RR_EN=0, D wins.
REQ-024 The last-served pointer SHALL reset to I, so D wins the first conflict after reset.
REQ-025 If d_read and d_write are both 1, the arbiter SHALL treat the request as a write.
REQ-026 RD_ISSUE SHALL assert bmem_read with the granted address until a cycle with bmem_ready=1, then go to RD_WAIT; bmem_read SHALL be 1 for exactly one accepted cycle.
REQ-027 RD_WAIT SHALL store beat k (k=0..3, counted by bmem_rvalid) into line bits [64k+63:64k], then go to RESP after the 4th beat.
REQ-028 Gaps between rvalid beats SHALL be tolerated.
REQ-029 bmem_rvalid outside RD_WAIT SHALL be ignored.
REQ-030 WR_BURST SHALL hold bmem_write=1 and bmem_addr constant, presenting d_wdata beat k on bmem_wdata; the beat counter SHALL advance only on bmem_ready=1.
REQ-031 After beat 3 is accepted, the FSM SHALL go to RESP.
REQ-032 RESP SHALL pulse the owner's resp for one cycle, with the owner's rdata valid for reads, update the last-served pointer, and return to IDLE.
REQ-033 Requests SHALL NOT be sampled in RESP; the requester drops its request the cycle after resp.
REQ-034 i_rdata and d_rdata SHALL be driven from one shared line buffer and hold their value until the next read fill.
REQ-035 The non-owner's request SHALL wait without loss; no request SHALL be granted twice.
REQ-036 Minimum read latency SHALL be request-to-resp = 3 cycles plus memory latency to the 4th beat; with ready=1 always, writes SHALL reach resp 6 cycles after request.

Reset
REQ-037 On rst, the FSM SHALL go to IDLE, beat counter=0, last-served=I, and the line buffer SHALL be cleared to 0.
REQ-038 All outputs SHALL be 0 during and after rst.
REQ-039 rst mid-burst SHALL abort the transaction with no resp issued.
REQ-040 Beats arriving after rst SHALL be ignored.

Verification
REQ-041 I read 0x0000_1234, memory returns beats 0x11..,0x22..,0x33..,0x44.. -> bmem_addr=0x0000_1220; i_rdata[63:0]=beat0, [255:192]=beat3; single-cycle i_resp.
REQ-042 i_read and d_read asserted in the same cycle after reset, RR_EN=1 -> D served first, then I; RR_EN=0 with D continuously re-requesting -> I starved, D always granted.
REQ-043 D write 0x8000_0040, d_wdata=256'h0123...cdef, bmem_ready low on 2nd beat for 2 cycles -> 4 beats in order, beat 1 held during stall, d_resp after beat 3.
REQ-044 rvalid gaps of 0-3 cycles between beats, plus a stray rvalid in IDLE -> correct line assembly, stray beat ignored.
REQ-045 rst asserted in RD_WAIT after 2 beats -> no resp, outputs 0; a following I read completes with fresh data.
